imem_prog_loader: RTL and testbench

// - Hardware writer for the core's instruction-memory setup port: assembles a byte stream into a

---
 rtl/imem_prog_loader_pkg.sv | 34 +++
 rtl/imem_prog_loader_bwa.sv | 46 ++++
 rtl/imem_prog_loader.sv | 140 ++++++++++++++
 tb/tb_imem_prog_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared constants for the instruction-memory program loader:
//               FSM state encoding, word geometry and header validation.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Bytes per instruction word; every stream field is one little-endian word.
    localparam int BYTES_PER_WORD = 4;

    // FSM state encoding. The header is two fields in a fixed order:
    // start address first (ST_HDR_ADDR), then word count (ST_HDR_CNT).
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_HDR_ADDR = 3'd0;
    localparam state_t ST_HDR_CNT  = 3'd1;
    localparam state_t ST_DATA     = 3'd2;
    localparam state_t ST_WRITE    = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_ERR      = 3'd5;

    // Header is acceptable when the start address is word aligned and the
    // count is in 1..max_words (count compared at full 32 bits).
    function automatic logic hdr_valid(input logic [31:0] start,
                                       input logic [31:0] count,
                                       input logic [31:0] max_words);
        return (start[1:0] == 2'b00) && (count != 32'd0) && (count <= max_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_prog_loader_bwa.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Collects four stream bytes into one little-endian 32-bit word
//               and flags the byte that completes it.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_cnt;
    // Only the three earlier bytes need storage; the fourth arrives live.
    logic [23:0] r_shift;

    // Byte counter and little-endian shift register; clear wins over a byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_cnt   <= 2'd0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    // Completed word is presented in the same cycle as its last byte.
    always_comb begin
        o_word          = {i_byte, r_shift};
        o_word_complete = i_byte_en && !i_clear && (r_cnt == c_last_byte);
    end

endmodule
`default_nettype wire

// File: rtl/imem_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_prog_loader
// Description : Turns a byte stream (start address, word count, words) into
//               instruction-memory writes and holds the core in setup until
//               a complete, valid image has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_prog_loader
    import imem_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    input  logic        i_reload,
    output logic        o_setup,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data,
    output logic [31:0] o_pc_start,
    output logic        o_done,
    output logic        o_error
);

    localparam int          K_W         = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_start;
    logic [31:0]    r_count;
    logic [K_W-1:0] r_k;

    logic           w_xfer;
    logic           w_reload;
    logic [31:0]    w_word;
    logic           w_word_done;
    logic [31:0]    w_k_ext;
    logic [31:0]    w_addr;
    logic           w_last_word;

    // Transfer qualification, reload gating and write address arithmetic.
    always_comb begin
        w_xfer      = i_byte_valid && o_byte_ready;
        w_reload    = i_reload && ((r_state == ST_DONE) || (r_state == ST_ERR));
        w_k_ext     = {{(32-K_W){1'b0}}, r_k};
        w_addr      = r_start + (w_k_ext << 2);
        w_last_word = (w_k_ext == (r_count - 32'd1));
    end

    byte_word_assembler u_bwa (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_reload),
        .i_byte_en       (w_xfer),
        .i_byte          (i_byte),
        .o_word          (w_word),
        .o_word_complete (w_word_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HDR_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR_ADDR: if (w_word_done) w_next = ST_HDR_CNT;
            ST_HDR_CNT:  if (w_word_done) w_next = hdr_valid(r_start, w_word, c_max_words)
                                                 ? ST_DATA : ST_ERR;
            ST_DATA:     if (w_word_done) w_next = ST_WRITE;
            ST_WRITE:    w_next = w_last_word ? ST_DONE : ST_DATA;
            ST_DONE,
            ST_ERR:      if (w_reload) w_next = ST_HDR_ADDR;
            default:     w_next = ST_HDR_ADDR;
        endcase
    end

    // Header fields and word index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 32'd0;
            r_count <= 32'd0;
            r_k     <= '0;
        end else begin
            if ((r_state == ST_HDR_ADDR) && w_word_done) begin
                r_start <= w_word;
            end
            if ((r_state == ST_HDR_CNT) && w_word_done) begin
                r_count <= w_word;
                r_k     <= '0;
            end
            if ((r_state == ST_WRITE) && !w_last_word) begin
                r_k     <= r_k + K_W'(1);
            end
        end
    end

    // Registered outputs, derived from the state being entered so that each
    // takes effect in the same cycle as that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_byte_ready <= 1'b0;
            o_setup      <= 1'b1;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= 32'd0;
            o_imem_data  <= 32'd0;
            o_pc_start   <= RESET_PC;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_byte_ready <= (w_next == ST_HDR_ADDR) || (w_next == ST_HDR_CNT) ||
                            (w_next == ST_DATA);
            o_imem_we    <= (w_next == ST_WRITE);
            o_setup      <= (w_next != ST_DONE);
            o_done       <= (w_next == ST_DONE);
            o_error      <= (w_next == ST_ERR);
            if (w_next == ST_WRITE) begin
                o_imem_addr <= w_addr;
                o_imem_data <= w_word;
            end
            if ((r_state == ST_WRITE) && (w_next == ST_DONE)) begin
                o_pc_start <= r_start;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_prog_loader
// Description : Directed self-checking bench for imem_prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_byte = 8'd0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic        i_reload = 1'b0;
    logic        o_setup;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic [31:0] o_pc_start;
    logic        o_done;
    logic        o_error;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    logic [31:0] img [4];

    // Write log captured away from the active edge.
    int          wr_n = 0;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_cyc  [32];

    imem_prog_loader #(.MAX_WORDS(1024), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .i_reload     (i_reload),
        .o_setup      (o_setup),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_pc_start   (o_pc_start),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_imem_we && (wr_n < 32)) begin
            wr_addr[wr_n] <= o_imem_addr;
            wr_data[wr_n] <= o_imem_data;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until a rising edge accepts it.
    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && (g < 200)) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        last_acc_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
    endtask

    // Header plus words from img; optional reload pulse inside the first word.
    task automatic load(input logic [31:0] s, input logic [31:0] n, input int gap,
                        input bit hdr_only, input bit reload_mid);
        logic [31:0] w;
        send_word(s, gap);
        send_word(n, gap);
        if (!hdr_only) begin
            for (int i = 0; i < int'(n); i++) begin
                w = img[i];
                for (int b = 0; b < 4; b++) begin
                    send_byte(w[8*b +: 8]);
                    if (reload_mid && (i == 0) && (b == 1)) pulse_reload();
                    repeat (gap) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_end(output int c);
        int g = 0;
        while (!(o_done || o_error) && (g < 500)) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("end_timeout", 32'd1, 32'd0);
        c = cyc;
    endtask

    initial begin
        int base;
        int c_end;

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_setup", o_setup,      1'b1);
        chk("rst_ready", o_byte_ready, 1'b0);
        chk("rst_pc",    o_pc_start,   32'h0);
        chk("rst_done",  o_done,       1'b0);
        rst = 1'b0;

        // Partial load interrupted by reset in the write cycle.
        img[0] = 32'h00124413;
        img[1] = 32'h006201B3;
        send_word(32'h4, 0);
        send_word(32'h2, 0);
        send_word(img[0], 0);
        chk("pre_rst_we", o_imem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_we",    o_imem_we,    1'b0);
        chk("midrst_setup", o_setup,      1'b1);
        chk("midrst_ready", o_byte_ready, 1'b0);
        chk("midrst_addr",  o_imem_addr,  32'h0);
        chk("midrst_data",  o_imem_data,  32'h0);
        chk("midrst_done",  o_done,       1'b0);
        chk("midrst_err",   o_error,      1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", o_byte_ready, 1'b1);

        // Basic full-rate load.
        base = wr_n;
        load(32'h4, 32'd2, 0, 1'b0, 1'b0);
        wait_end(c_end);
        chk("basic_nwr",   32'(wr_n - base), 32'd2);
        chk("basic_addr0", wr_addr[base],    32'h4);
        chk("basic_data0", wr_data[base],    32'h00124413);
        chk("basic_addr1", wr_addr[base+1],  32'h8);
        chk("basic_data1", wr_data[base+1],  32'h006201B3);
        chk("basic_gap",   32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
        chk("basic_lat",   32'(wr_cyc[base+1]), 32'(last_acc_cyc));
        chk("basic_donet", 32'(c_end), 32'(wr_cyc[base+1] + 1));
        chk("basic_setup", o_setup,    1'b0);
        chk("basic_done",  o_done,     1'b1);
        chk("basic_pc",    o_pc_start, 32'h4);
        chk("basic_ready", o_byte_ready, 1'b0);

        // Same image with valid low between bytes.
        pulse_reload();
        chk("rl1_setup", o_setup, 1'b1);
        chk("rl1_done",  o_done,  1'b0);
        base = wr_n;
        load(32'h4, 32'd2, 3, 1'b0, 1'b0);
        wait_end(c_end);
        repeat (4) @(negedge clk);
        chk("gap_nwr",   32'(wr_n - base), 32'd2);
        chk("gap_addr0", wr_addr[base],    32'h4);
        chk("gap_data0", wr_data[base],    32'h00124413);
        chk("gap_addr1", wr_addr[base+1],  32'h8);
        chk("gap_data1", wr_data[base+1],  32'h006201B3);
        chk("gap_done",  o_done,           1'b1);

        // Reload with a new image; a reload pulse during DATA is ignored.
        img[0] = 32'h00C00213;
        pulse_reload();
        chk("rl2_setup", o_setup,    1'b1);
        chk("rl2_pc",    o_pc_start, 32'h4);
        base = wr_n;
        load(32'h40, 32'd1, 0, 1'b0, 1'b1);
        wait_end(c_end);
        chk("rl2_nwr",  32'(wr_n - base), 32'd1);
        chk("rl2_addr", wr_addr[base],    32'h40);
        chk("rl2_data", wr_data[base],    32'h00C00213);
        chk("rl2_pc2",  o_pc_start,       32'h40);
        chk("rl2_done", o_done,           1'b1);

        // Header errors: misaligned start, zero count, count too large.
        pulse_reload();
        base = wr_n;
        load(32'h6, 32'd1, 0, 1'b1, 1'b0);
        wait_end(c_end);
        chk("err_align_err",   o_error, 1'b1);
        chk("err_align_setup", o_setup, 1'b1);
        chk("err_align_done",  o_done,  1'b0);
        chk("err_align_pc",    o_pc_start, 32'h40);

        pulse_reload();
        chk("err_rl_err", o_error, 1'b0);
        load(32'h0, 32'd0, 0, 1'b1, 1'b0);
        wait_end(c_end);
        chk("err_zero_err",   o_error, 1'b1);
        chk("err_zero_setup", o_setup, 1'b1);

        pulse_reload();
        load(32'h0, 32'd1025, 0, 1'b1, 1'b0);
        wait_end(c_end);
        repeat (3) @(negedge clk);
        chk("err_big_err",   o_error, 1'b1);
        chk("err_big_setup", o_setup, 1'b1);
        chk("err_nwr",       32'(wr_n - base), 32'd0);

        // Address wrap past the top of the 32-bit space.
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h12345678;
        pulse_reload();
        base = wr_n;
        load(32'hFFFFFFFC, 32'd2, 0, 1'b0, 1'b0);
        wait_end(c_end);
        chk("wrap_nwr",   32'(wr_n - base), 32'd2);
        chk("wrap_addr0", wr_addr[base],    32'hFFFFFFFC);
        chk("wrap_data0", wr_data[base],    32'hDEADBEEF);
        chk("wrap_addr1", wr_addr[base+1],  32'h00000000);
        chk("wrap_data1", wr_data[base+1],  32'h12345678);
        chk("wrap_pc",    o_pc_start,       32'hFFFFFFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
